// File: rtl/pzcorebus_sram_slave.sv
// Corebus memory-profile slave: terminates command, write-data and response
// channels on a word-addressed register array, one command in flight at a time.
module pzcorebus_sram_slave #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_LENGTH    = 4,
  parameter int LENGTH_WIDTH  = $clog2(MAX_LENGTH),
  parameter int DEPTH         = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_scmd_valid,
  output logic                     o_scmd_accept,
  input  logic [3:0]               i_scmd_command,
  input  logic [ID_WIDTH-1:0]      i_scmd_id,
  input  logic [ADDRESS_WIDTH-1:0] i_scmd_address,
  input  logic [LENGTH_WIDTH-1:0]  i_scmd_length,
  input  logic                     i_sreq_valid,
  output logic                     o_sreq_accept,
  input  logic [DATA_WIDTH-1:0]    i_sreq_data,
  input  logic [DATA_WIDTH/8-1:0]  i_sreq_byte_enable,
  input  logic                     i_sreq_last,
  output logic                     o_sres_valid,
  input  logic                     i_sres_accept,
  output logic                     o_sres_response_type,
  output logic [ID_WIDTH-1:0]      o_sres_id,
  output logic                     o_sres_error,
  output logic [DATA_WIDTH-1:0]    o_sres_data,
  output logic [1:0]               o_sres_last
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(BE_WIDTH);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = LENGTH_WIDTH + 1;
  localparam logic [3:0] CMD_READ = 4'b1001;

  typedef enum logic [1:0] {IDLE, WRITE_DATA, READ_RESP, WRITE_RESP} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    np_q, np_d;
  logic                    wr_q, wr_d;
  logic                    full_q, full_d;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] addr_hi;
  logic                     range_err;
  logic [CNT_W-1:0]         cmd_len;
  logic [IDX_W-1:0]         beat_idx;
  logic                     last_beat;

  assign addr_hi   = i_scmd_address >> (OFF_W + IDX_W);
  assign range_err = |addr_hi;
  assign cmd_len   = (i_scmd_length == '0) ? CNT_W'(MAX_LENGTH) : {1'b0, i_scmd_length};
  assign beat_idx  = idx_q + IDX_W'(cnt_q);
  assign last_beat = ((cnt_q + CNT_W'(1)) == len_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      np_q    <= 1'b0;
      wr_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      np_q    <= np_d;
      wr_q    <= wr_d;
      full_q  <= full_d;
    end
  end

  // NOTE: the array has no reset branch; contents survive reset and map onto plain storage.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (full_q || i_sreq_byte_enable[b]) mem[beat_idx][8*b +: 8] <= i_sreq_data[8*b +: 8];
      end
    end
  end

  // NOTE: every signal gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d              = state_q;
    id_d                 = id_q;
    idx_d                = idx_q;
    len_d                = len_q;
    cnt_d                = cnt_q;
    err_d                = err_q;
    np_d                 = np_q;
    wr_d                 = wr_q;
    full_d               = full_q;
    mem_we               = 1'b0;
    o_scmd_accept        = 1'b0;
    o_sreq_accept        = 1'b0;
    o_sres_valid         = 1'b0;
    o_sres_response_type = 1'b0;
    o_sres_id            = '0;
    o_sres_error         = 1'b0;
    o_sres_data          = '0;
    o_sres_last          = 2'b00;

    unique case (state_q)
      IDLE: begin
        o_scmd_accept = !i_rst;
        if (i_scmd_valid) begin
          id_d   = i_scmd_id;
          idx_d  = i_scmd_address[OFF_W +: IDX_W];
          len_d  = cmd_len;
          cnt_d  = '0;
          np_d   = i_scmd_command[3];
          wr_d   = i_scmd_command[2] && !i_scmd_command[1] && !range_err;
          full_d = i_scmd_command[0];
          if (i_scmd_command == CMD_READ) begin
            err_d   = range_err;
            state_d = READ_RESP;
          end else if (i_scmd_command[2]) begin
            // Broadcast and atomic payloads are drained without touching memory.
            err_d   = range_err || i_scmd_command[1];
            state_d = WRITE_DATA;
          end else if (i_scmd_command[3]) begin
            err_d   = 1'b1;
            state_d = WRITE_RESP;
          end
        end
      end
      WRITE_DATA: begin
        o_sreq_accept = !i_rst;
        if (i_sreq_valid && !i_rst) begin
          mem_we = wr_q;
          if (i_sreq_last != last_beat) err_d = 1'b1;
          if (last_beat) state_d = np_q ? WRITE_RESP : IDLE;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      READ_RESP: begin
        o_sres_valid         = 1'b1;
        o_sres_response_type = 1'b1;
        o_sres_id            = id_q;
        o_sres_error         = err_q;
        o_sres_data          = err_q ? '0 : mem[beat_idx];
        o_sres_last          = last_beat ? 2'b11 : 2'b00;
        if (i_sres_accept) begin
          if (last_beat) state_d = IDLE;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      WRITE_RESP: begin
        o_sres_valid = 1'b1;
        o_sres_id    = id_q;
        o_sres_error = err_q;
        o_sres_last  = 2'b11;
        if (i_sres_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pzcorebus_sram_slave.sv
// Directed bench for pzcorebus_sram_slave: writes, reads, wrap, errors, stalls and reset.
module tb_pzcorebus_sram_slave;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_scmd_valid;
  logic        o_scmd_accept;
  logic [3:0]  i_scmd_command;
  logic [7:0]  i_scmd_id;
  logic [15:0] i_scmd_address;
  logic [1:0]  i_scmd_length;
  logic        i_sreq_valid;
  logic        o_sreq_accept;
  logic [31:0] i_sreq_data;
  logic [3:0]  i_sreq_byte_enable;
  logic        i_sreq_last;
  logic        o_sres_valid;
  logic        i_sres_accept;
  logic        o_sres_response_type;
  logic [7:0]  o_sres_id;
  logic        o_sres_error;
  logic [31:0] o_sres_data;
  logic [1:0]  o_sres_last;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pzcorebus_sram_slave dut (
    .i_clk                (clk),
    .i_rst                (i_rst),
    .i_scmd_valid         (i_scmd_valid),
    .o_scmd_accept        (o_scmd_accept),
    .i_scmd_command       (i_scmd_command),
    .i_scmd_id            (i_scmd_id),
    .i_scmd_address       (i_scmd_address),
    .i_scmd_length        (i_scmd_length),
    .i_sreq_valid         (i_sreq_valid),
    .o_sreq_accept        (o_sreq_accept),
    .i_sreq_data          (i_sreq_data),
    .i_sreq_byte_enable   (i_sreq_byte_enable),
    .i_sreq_last          (i_sreq_last),
    .o_sres_valid         (o_sres_valid),
    .i_sres_accept        (i_sres_accept),
    .o_sres_response_type (o_sres_response_type),
    .o_sres_id            (o_sres_id),
    .o_sres_error         (o_sres_error),
    .o_sres_data          (o_sres_data),
    .o_sres_last          (o_sres_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] cmd, input logic [7:0] id,
                          input logic [15:0] addr, input logic [1:0] len);
    @(negedge clk);
    i_scmd_valid   = 1'b1;
    i_scmd_command = cmd;
    i_scmd_id      = id;
    i_scmd_address = addr;
    i_scmd_length  = len;
    for (int i = 0; i < 20 && !o_scmd_accept; i++) @(negedge clk);
    check("cmd_accept", o_scmd_accept, 1);
    @(posedge clk);
    #1 i_scmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [3:0] be, input logic last);
    @(negedge clk);
    i_sreq_valid       = 1'b1;
    i_sreq_data        = data;
    i_sreq_byte_enable = be;
    i_sreq_last        = last;
    for (int i = 0; i < 20 && !o_sreq_accept; i++) @(negedge clk);
    check("req_accept", o_sreq_accept, 1);
    @(posedge clk);
    #1 i_sreq_valid = 1'b0;
  endtask

  task automatic recv_beat(input string tag, input logic rtype, input logic [7:0] id,
                           input logic err, input logic [31:0] data, input logic [1:0] last);
    @(negedge clk);
    for (int i = 0; i < 20 && !o_sres_valid; i++) @(negedge clk);
    check({tag, "_valid"}, o_sres_valid, 1);
    check({tag, "_type"},  o_sres_response_type, rtype);
    check({tag, "_id"},    o_sres_id, id);
    check({tag, "_err"},   o_sres_error, err);
    check({tag, "_data"},  o_sres_data, data);
    check({tag, "_last"},  o_sres_last, last);
    i_sres_accept = 1'b1;
    @(posedge clk);
    #1 i_sres_accept = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    i_scmd_valid = 1'b0; i_scmd_command = '0; i_scmd_id = '0; i_scmd_address = '0; i_scmd_length = '0;
    i_sreq_valid = 1'b0; i_sreq_data = '0; i_sreq_byte_enable = '0; i_sreq_last = 1'b0;
    i_sres_accept = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_accept", o_scmd_accept, 1);
    check("rst_req_accept", o_sreq_accept, 0);
    check("rst_res_valid",  o_sres_valid, 0);
    check("rst_res_data",   o_sres_data, 0);
    check("rst_res_last",   o_sres_last, 0);

    // Non-posted write of two beats, then read them back.
    send_cmd(4'b1100, 8'h12, 16'h0010, 2'd2);
    send_beat(32'hAAAA_0001, 4'hF, 1'b0);
    send_beat(32'hBBBB_0002, 4'hF, 1'b1);
    recv_beat("wr_resp", 1'b0, 8'h12, 1'b0, 32'h0, 2'b11);
    send_cmd(4'b1001, 8'h34, 16'h0010, 2'd2);
    check("rd_first_latency", o_sres_valid, 1);
    recv_beat("rd0", 1'b1, 8'h34, 1'b0, 32'hAAAA_0001, 2'b00);
    recv_beat("rd1", 1'b1, 8'h34, 1'b0, 32'hBBBB_0002, 2'b11);

    // Posted byte-enable write over a preloaded word; no response expected.
    send_cmd(4'b0100, 8'h01, 16'h0020, 2'd1);
    send_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
    send_cmd(4'b0100, 8'h02, 16'h0020, 2'd1);
    send_beat(32'h1122_3344, 4'b0101, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("posted_no_resp", o_sres_valid, 0);
    end
    send_cmd(4'b1001, 8'h03, 16'h0020, 2'd1);
    recv_beat("be_rd", 1'b1, 8'h03, 1'b0, 32'hFF22_FF44, 2'b11);

    // Full write ignores byte enables.
    send_cmd(4'b0101, 8'h04, 16'h0024, 2'd1);
    send_beat(32'hCAFE_BABE, 4'h0, 1'b1);
    send_cmd(4'b1001, 8'h05, 16'h0024, 2'd1);
    recv_beat("full_rd", 1'b1, 8'h05, 1'b0, 32'hCAFE_BABE, 2'b11);

    // Wrapping four-beat write and read at the top of the array, with a stall.
    send_cmd(4'b1100, 8'h06, 16'h03FC, 2'd0);
    send_beat(32'h5000_00FF, 4'hF, 1'b0);
    send_beat(32'h5000_0000, 4'hF, 1'b0);
    send_beat(32'h5000_0001, 4'hF, 1'b0);
    send_beat(32'h5000_0002, 4'hF, 1'b1);
    recv_beat("wrap_wr_resp", 1'b0, 8'h06, 1'b0, 32'h0, 2'b11);
    send_cmd(4'b1001, 8'h07, 16'h03FC, 2'd0);
    recv_beat("wrap0", 1'b1, 8'h07, 1'b0, 32'h5000_00FF, 2'b00);
    recv_beat("wrap1", 1'b1, 8'h07, 1'b0, 32'h5000_0000, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_valid", o_sres_valid, 1);
      check("stall_data",  o_sres_data, 32'h5000_0001);
      check("stall_last",  o_sres_last, 2'b00);
    end
    recv_beat("wrap2", 1'b1, 8'h07, 1'b0, 32'h5000_0001, 2'b00);
    recv_beat("wrap3", 1'b1, 8'h07, 1'b0, 32'h5000_0002, 2'b11);

    // Out-of-range read.
    send_cmd(4'b1001, 8'h08, 16'h0400, 2'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("oor_cmd_blocked", o_scmd_accept, 0);
    end
    recv_beat("oor_rd", 1'b1, 8'h08, 1'b1, 32'h0, 2'b11);
    @(negedge clk);
    check("oor_cmd_reopen", o_scmd_accept, 1);

    // Early last on a two-beat non-posted write.
    send_cmd(4'b1100, 8'h09, 16'h0050, 2'd2);
    send_beat(32'h0000_1111, 4'hF, 1'b1);
    send_beat(32'h0000_2222, 4'hF, 1'b0);
    recv_beat("last_err_resp", 1'b0, 8'h09, 1'b1, 32'h0, 2'b11);

    // Unsupported non-posted message and non-posted broadcast.
    send_cmd(4'b1000, 8'h0A, 16'h0000, 2'd1);
    recv_beat("msg_np_resp", 1'b0, 8'h0A, 1'b1, 32'h0, 2'b11);
    send_cmd(4'b0100, 8'h0B, 16'h0040, 2'd1);
    send_beat(32'h1234_5678, 4'hF, 1'b1);
    send_cmd(4'b1110, 8'h0C, 16'h0040, 2'd1);
    send_beat(32'h0000_DEAD, 4'hF, 1'b1);
    recv_beat("bcast_resp", 1'b0, 8'h0C, 1'b1, 32'h0, 2'b11);
    send_cmd(4'b1001, 8'h0D, 16'h0040, 2'd1);
    recv_beat("bcast_rd", 1'b1, 8'h0D, 1'b0, 32'h1234_5678, 2'b11);

    // Reset in the middle of a four-beat read, then a clean read.
    send_cmd(4'b1001, 8'h0E, 16'h03FC, 2'd0);
    recv_beat("rst_rd0", 1'b1, 8'h0E, 1'b0, 32'h5000_00FF, 2'b00);
    @(negedge clk);
    check("pre_rst_valid", o_sres_valid, 1);
    i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", o_sres_valid, 0);
    check("post_rst_accept", o_scmd_accept, 1);
    send_cmd(4'b1001, 8'h0F, 16'h0014, 2'd1);
    recv_beat("post_rst_rd", 1'b1, 8'h0F, 1'b0, 32'hBBBB_0002, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pzcorebus_sram_slave.md
Name: pzcorebus_sram_slave

Overview:
- Corebus memory-profile slave endpoint. Sits directly downstream of a corebus master (or interconnect) and terminates command, request-data and response channels on an internal word-addressed register-array memory.
- Serves as the reference target for bus-level VIP regressions and as a scratch memory in subsystem benches.
- One command in flight at a time; no command pipelining.

Parameters:
- ID_WIDTH, 8, command/response id width.
- ADDRESS_WIDTH, 16, byte address width.
- DATA_WIDTH, 32, data width; a multiple of 32. BE_WIDTH = DATA_WIDTH/8.
- MAX_LENGTH, 4, maximum burst length in beats; a power of two, ≥ 2.
- LENGTH_WIDTH, $clog2(MAX_LENGTH), length field width.
- DEPTH, 256, memory words; a power of two.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_scmd_valid  input  1  command valid
- o_scmd_accept  output  1  command accept
- i_scmd_command  input  4  command code: bit3 non-posted, bit2 carries data
- i_scmd_id  input  ID_WIDTH  command id
- i_scmd_address  input  ADDRESS_WIDTH  byte address
- i_scmd_length  input  LENGTH_WIDTH  beats; value 0 encodes MAX_LENGTH
- i_sreq_valid  input  1  write-data valid
- o_sreq_accept  output  1  write-data accept
- i_sreq_data  input  DATA_WIDTH  write data
- i_sreq_byte_enable  input  BE_WIDTH  byte enables
- i_sreq_last  input  1  final write beat
- o_sres_valid  output  1  response valid
- i_sres_accept  input  1  response accept
- o_sres_response_type  output  1  0 = response, 1 = response with data
- o_sres_id  output  ID_WIDTH  echoed command id
- o_sres_error  output  1  error flag
- o_sres_data  output  DATA_WIDTH  read data
- o_sres_last  output  2  [0] final beat of burst, [1] final beat of response

Behaviour:
- Reset: synchronous, active-high. State IDLE. All outputs 0 except o_scmd_accept = 1 in the cycle after reset deasserts. Memory contents are not reset.
- Reset mid-operation aborts the transaction. Beats already written stay in memory. No response is issued.
- Handshake: a transfer occurs when valid && accept on the same edge. Once asserted, o_sres_valid and its payload hold until accepted.
- Word index = address[log2(BE_WIDTH) +: log2(DEPTH)]. Beat k uses index (base + k) mod DEPTH, so bursts wrap at the array top.
- Out-of-range: any address bit above the index field set → error = 1, no memory access.
- FSM states: IDLE, WRITE_DATA, READ_RESP, WRITE_RESP. o_scmd_accept = 1 only in IDLE. o_sreq_accept = 1 only in WRITE_DATA.
- IDLE, on command handshake: latch id, index, length, command.
  - READ (4'b1001) → READ_RESP.
  - Command with bit2 set → WRITE_DATA.
  - Any other command → WRITE_RESP if bit3 set, else stay in IDLE.
- WRITE_DATA:
  - Each accepted beat updates the selected word with per-byte enables; the update is visible to a read issued the following cycle.
  - FULL_WRITE (4'b?101) ignores byte enables and writes all bytes.
  - Writes occur only for WRITE / FULL_WRITE and only when in range. BROADCAST and ATOMIC data beats are drained, not written, and flag error.
  - Burst ends on beat number length. If i_sreq_last disagrees with the count on any beat, latch error.
  - At burst end: → WRITE_RESP if non-posted, else → IDLE.
- WRITE_RESP: o_sres_valid = 1, response_type 0, data 0, last = 2'b11, error as latched. → IDLE on accept.
- Unsupported non-posted commands (MESSAGE_NP, non-data codes other than READ) also respond with error = 1. NULL and posted unsupported commands are dropped silently.
- READ_RESP:
  - First beat valid the cycle after command accept.
  - Each beat: response_type 1, data = mem[index + k], or 0 on error.
  - Next beat valid the cycle after acceptance; back-to-back beats are allowed with valid held high.
  - Final beat: last = 2'b11, otherwise 2'b00. → IDLE on final accept.
- Length counter width is LENGTH_WIDTH + 1. Length 0 means MAX_LENGTH beats.

Test Plan:
- Non-posted write id 0x12, addr 0x0010, len 2, data 0xAAAA_0001/0xBBBB_0002, be 4'hF, last on beat 2 → single response: type 0, id 0x12, error 0, last 2'b11. Then read len 2 → beats 0xAAAA_0001, 0xBBBB_0002, last 2'b00 then 2'b11.
- Posted write addr 0x0020, be 4'b0101, data 0x1122_3344 over a word preloaded with 0xFFFF_FFFF → no response. Read returns 0xFF22_FF44.
- Read addr 0x03FC, len 0 (4 beats) → indices 255, 0, 1, 2 returned in order. Hold i_sres_accept low 3 cycles on beat 2 → payload stable throughout.
- Read addr 0x0400 → 1 beat: type 1, data 0, error 1. o_scmd_accept stays low until that beat is accepted.
- Write len 2 with i_sreq_last asserted on beat 1, non-posted → both beats accepted, response error 1.
- Assert i_rst mid-read on beat 2 of 4 → next cycle o_sres_valid 0, o_scmd_accept 1. A new read completes normally.
